// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan capture block: segment patterns
// {g,f,e,d,c,b,a} for the hex digits and the capture FSM state type.
package seg7_pkg;

   localparam int unsigned DEFAULT_DIGITS = 8;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display-side lines plus the reconstructed-frame results of the scan capture block.
interface seg7_scan_capture_if import seg7_pkg::*; #(
   parameter int unsigned DIGITS = DEFAULT_DIGITS
);
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp_mask;
   logic                frame_err;
   logic                frame_valid;
   logic                frame_lost;
   logic [7:0]          glitch_cnt;

   modport master (
      output seg, dp, an,
      input  value, dp_mask, frame_err, frame_valid, frame_lost, glitch_cnt
   );

   modport slave (
      input  seg, dp, an,
      output value, dp_mask, frame_err, frame_valid, frame_lost, glitch_cnt
   );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Segment pattern to hex nibble; unknown patterns give nibble 0 with err set.
module seg7_pattern_decode import seg7_pkg::*; (
   input  logic [6:0] pattern,
   output logic       err,
   output logic [3:0] nibble
);
   always_comb begin
      err    = 1'b0;
      nibble = 4'h0;
      case (pattern)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: err    = 1'b1;
      endcase
   end
endmodule

// File: rtl/seg7_scan_capture.sv
// Watches a scanned multi-digit 7-segment display and rebuilds the hex value
// shown, one debounced digit at a time, reporting each complete frame.
module seg7_scan_capture import seg7_pkg::*; #(
   parameter int unsigned DIGITS     = DEFAULT_DIGITS,
   parameter int unsigned STABLE_CYC = 4,
   parameter int unsigned TIMEOUT    = 1000000
) (
   input logic              clk,
   input logic              reset,
   seg7_scan_capture_if.slave bus
);
   localparam int unsigned SW = DIGITS + 8;
   localparam int unsigned CW = $clog2(STABLE_CYC + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SW-1:0]       sync1_q, sample_q, ref_q, ref_d;
   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [TW-1:0]       idle_q, idle_d;
   logic [DIGITS-1:0]   mask_q, mask_d, slot_dp_q, slot_dp_d, slot_err_q, slot_err_d;
   logic [4*DIGITS-1:0] slot_nib_q, slot_nib_d, value_q, value_d;
   logic [DIGITS-1:0]   dp_mask_q, dp_mask_d;
   logic                frame_err_q, frame_err_d;
   logic                done_q, done_d, frame_valid_q, lost_q, lost_d;
   logic [7:0]          glitch_q, glitch_d;
   logic                accept, one_hot, dec_err;
   logic [3:0]          dec_nibble;
   logic [IW-1:0]       idx;
   logic [DIGITS-1:0]   sample_an, ref_an;

   assign sample_an = sample_q[SW-1:8];
   assign ref_an    = ref_q[SW-1:8];
   assign one_hot   = (ref_an != '0) && ((ref_an & (ref_an - 1'b1)) == '0);

   seg7_pattern_decode u_decode (
      .pattern (ref_q[6:0]),
      .err     (dec_err),
      .nibble  (dec_nibble)
   );

   always_comb begin
      idx = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (ref_an[i]) idx = IW'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample_an != '0) begin
               state_d = SETTLE;
               ref_d   = sample_q;
               cnt_d   = CW'(1);
            end
         end
         SETTLE: begin
            if (sample_q != ref_q) begin
               if (sample_an == '0) begin
                  state_d = IDLE;
               end else begin
                  ref_d = sample_q;
                  cnt_d = CW'(1);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CW'(STABLE_CYC)) begin
                  accept  = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // Segment changes under an unchanged select are ignored here.
            if (sample_an == '0) begin
               state_d = IDLE;
            end else if (sample_an != ref_an) begin
               state_d = SETTLE;
               ref_d   = sample_q;
               cnt_d   = CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      slot_nib_d  = slot_nib_q;
      slot_dp_d   = slot_dp_q;
      slot_err_d  = slot_err_q;
      mask_d      = mask_q;
      done_d      = 1'b0;
      lost_d      = 1'b0;
      idle_d      = idle_q;
      glitch_d    = glitch_q;
      value_d     = value_q;
      dp_mask_d   = dp_mask_q;
      frame_err_d = frame_err_q;

      if (done_q) begin
         value_d     = slot_nib_q;
         dp_mask_d   = slot_dp_q;
         frame_err_d = |slot_err_q;
         mask_d      = '0;
         slot_err_d  = '0;
      end

      // Accept has priority over the timeout and restarts the idle count.
      if (accept) begin
         idle_d = '0;
      end else if (idle_q == TW'(TIMEOUT - 1)) begin
         if (mask_q != '0) begin
            lost_d = 1'b1;
            mask_d = '0;
            idle_d = '0;
         end
      end else begin
         idle_d = idle_q + 1'b1;
      end

      if (accept && one_hot) begin
         slot_nib_d[{idx, 2'b00} +: 4] = dec_nibble;
         slot_dp_d[idx]                = ref_q[7];
         slot_err_d[idx]               = dec_err;
         mask_d                        = mask_d | ref_an;
         done_d                        = &(mask_q | ref_an);
      end else if (accept && glitch_q != 8'hFF) begin
         glitch_d = glitch_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q       <= '0;
         sample_q      <= '0;
         ref_q         <= '0;
         state_q       <= IDLE;
         cnt_q         <= '0;
         idle_q        <= '0;
         mask_q        <= '0;
         slot_nib_q    <= '0;
         slot_dp_q     <= '0;
         slot_err_q    <= '0;
         value_q       <= '0;
         dp_mask_q     <= '0;
         frame_err_q   <= 1'b0;
         done_q        <= 1'b0;
         frame_valid_q <= 1'b0;
         lost_q        <= 1'b0;
         glitch_q      <= '0;
      end else begin
         sync1_q       <= {bus.an, bus.dp, bus.seg};
         sample_q      <= sync1_q;
         ref_q         <= ref_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idle_q        <= idle_d;
         mask_q        <= mask_d;
         slot_nib_q    <= slot_nib_d;
         slot_dp_q     <= slot_dp_d;
         slot_err_q    <= slot_err_d;
         value_q       <= value_d;
         dp_mask_q     <= dp_mask_d;
         frame_err_q   <= frame_err_d;
         done_q        <= done_d;
         frame_valid_q <= done_q;
         lost_q        <= lost_d;
         glitch_q      <= glitch_d;
      end
   end

   assign bus.value       = value_q;
   assign bus.dp_mask     = dp_mask_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_lost  = lost_q;
   assign bus.glitch_cnt  = glitch_q;
endmodule
